uart_mux: RTL and testbench
===========================

# uart_mux

Packet transmitter for the host debug link: the sending counterpart of the UART packet demultiplexer. Client logic buffers up to 256 payload bytes, then commits them with an 8-bit address. The block serialises one packet on `UART_TX`: checksum byte, address, count, then the data bytes. Sits beside the receive demux at the top level and drives the board TX pin.

## Interface
- `CLKS_PER_BIT`, 100, clock cycles per UART bit (115200 baud at the system clock)
- `clk`  in  1  system clock
- `RESET`  in  1  reset, synchronous, active-high; clock clk
- `wr`  in  1  append `wr_data` to payload buffer
- `wr_data`  in  8  payload byte
- `commit`  in  1  start transmitting the buffered payload
- `commit_addr`  in  8  packet address, sampled with `commit`
- `UART_TX`  out  1  serial line, idle high
- `busy`  out  1  packet being transmitted
- `fill`  out  9  payload bytes buffered, 0..256
- `done`  out  1  one-cycle pulse, packet fully sent
- `overflow`  out  1  sticky dropped-write flag (see Configuration)

## Operation
- Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts `CLKS_PER_BIT` cycles.
- Packet byte order: CKSUM, ADDR, COUNT, then DATA[0..N-1].
  - COUNT = N mod 256; N=256 sends 0x00.
  - CKSUM = -(ADDR + COUNT + ΣDATA) mod 256, so the 8-bit sum of all packet bytes is 0.
- Fill phase (`busy`=0):
  - `wr` stores the byte at index `fill`, increments `fill`, and adds it to the 8-bit running sum.
  - `wr` when `fill`=256 is dropped.
- `commit` with `busy`=0 and `fill`≥1 latches `commit_addr`, computes CKSUM, and enters CKSUM.
  - `commit` with `fill`=0 is ignored.
  - `commit` while busy is ignored.
- `wr` and `commit` in the same idle cycle: the byte is stored first and is included in the packet.
- `wr` while busy is dropped. Buffer contents and sum are unaffected.
- FSM states: IDLE → CKSUM → ADDR → COUNT → DATA → IDLE.
  - DATA stays until index N-1 has been handed to the byte transmitter.
  - Return to IDLE happens when the last stop bit completes.
  - On return to IDLE: `done`=1 for one cycle, `busy`=0, `fill`=0, sum cleared.
- Reset values: `UART_TX`=1, `busy`=0, `fill`=0, `done`=0, `overflow`=0, state IDLE.
- Reset mid-packet: the line goes high on the next cycle and the buffer is emptied. The truncated packet is not resumed.

## Timing
- `commit` sampled at edge t: `busy`=1 from t+1, and `UART_TX` falls (CKSUM start bit) at t+2.
- Consecutive packet bytes start exactly 10·`CLKS_PER_BIT`+1 cycles apart (one idle-high cycle between bytes).
- Packet of N bytes occupies (N+3)·(10·`CLKS_PER_BIT`+1) cycles from the first start bit.
- `done` asserts on the cycle after the final stop bit's last cycle. `busy` drops on that same cycle.
- A new `wr` is accepted on the same cycle as `done`.

## Configuration
- `UART_MUX_OVF_EN` defined:
  - Any dropped `wr` (while busy, or with `fill`=256) sets `overflow`.
  - `overflow` clears only on `RESET`.
- Not defined: `overflow` is tied 0, and drops are silent. Datapath is otherwise identical.

## Structure
- Package `uart_mux_pkg`:
  - FSM state enum
  - `FRAME_BITS`=10
  - `MAX_PAYLOAD`=256
  - checksum function (negated 8-bit sum)
- Payload buffer: 256×8 inferred RAM, written by fill index, read by send index.
- Sub-module `uart_tx_byte`:
  - Parameter `CLKS_PER_BIT`; `valid`/`ready` byte input; `tx` output.
  - `ready` is high in idle.
  - The byte is accepted on `valid && ready`; the start bit goes out the next cycle.
  - `ready` returns one cycle after the stop bit ends.

## Test plan
- Write 0x34, commit addr 0x12 → line carries B9 12 01 34 at 10·`CLKS_PER_BIT`+1 spacing. Receive demux loopback writes 0x34 to addr 0x12 with `checksum_error`=0.
- Write 0x00..0xFF (256 bytes), commit addr 0x00 → COUNT 0x00, CKSUM 0x80; demux delivers all 256 bytes with no error; `done` pulses once.
- `commit` with `fill`=0 → `UART_TX` stays high, `busy`/`done` stay 0.
- 3-byte packet; `wr` 0xAA during transmission → packet bytes unchanged; `overflow`=1 only with `UART_MUX_OVF_EN`; `fill`=0 after `done`.
- 257th `wr` after 256 writes → `fill` stays 256; byte absent from packet.
- `RESET` during the ADDR byte → `UART_TX`=1 next cycle, `fill`=0, `busy`=0; a fresh 1-byte packet then transmits correctly.

Source files
------------

// File: rtl/uart_mux_pkg.sv
// uart_mux_pkg: shared FSM state, framing constants and packet checksum helper for uart_mux.
package uart_mux_pkg;
  typedef enum logic [2:0] {IDLE, CKSUM, ADDR, COUNT, DATA} state_t;
  localparam int FRAME_BITS = 10;
  localparam int MAX_PAYLOAD = 256;
  function automatic logic [7:0] cksum(input logic [7:0] a, input logic [7:0] c, input logic [7:0] s);
    return -(a + c + s);
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser with a valid/ready byte input; the line idles high.
module uart_tx_byte import uart_mux_pkg::*; #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  logic [FRAME_BITS-1:0] sh;
  logic [CW-1:0] cnt;
  logic [3:0] bits;
  logic act;
  // the frame is shifted out LSB first with ones back-filled, so the idle line is high
  always_ff @(posedge clk) begin
    if (RESET) begin
      act <= 1'b0;
      sh <= '1;
      cnt <= '0;
      bits <= '0;
    end else if (!act) begin
      if (valid) begin
        act <= 1'b1;
        sh <= {1'b1, data, 1'b0};
        cnt <= '0;
        bits <= '0;
      end
    end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
      cnt <= '0;
      sh <= {1'b1, sh[FRAME_BITS-1:1]};
      bits <= bits + 1'b1;
      act <= bits != 4'(FRAME_BITS - 1);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign ready = !act;
  assign tx = sh[0];
endmodule

// File: rtl/uart_mux.sv
// uart_mux: buffers up to 256 payload bytes and sends CKSUM, ADDR, COUNT, DATA over UART.
// Define UART_MUX_OVF_EN to make dropped writes set the sticky overflow flag.
module uart_mux import uart_mux_pkg::*; #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [7:0] commit_addr,
  output logic       UART_TX,
  output logic       busy,
  output logic [8:0] fill,
  output logic       done,
  output logic       overflow
);
  state_t state, state_n;
  logic [7:0] mem [MAX_PAYLOAD];
  logic [8:0] fill_q, fill_eff, fill_n;
  logic [7:0] sum_q, sum_eff, sum_n, addr_q, ck_q, idx, tx_data;
  logic last_q, wr_ok, start, valid, ready;
  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = CKSUM;
      CKSUM: if (ready) state_n = ADDR;
      ADDR: if (ready) state_n = COUNT;
      COUNT: if (ready) state_n = DATA;
      DATA: if (done) state_n = start ? CKSUM : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // done is the first cycle the transmitter is free after the last data byte
  always_comb begin
    done = state == DATA && last_q && ready;
    busy = state != IDLE && !done;
    valid = state == CKSUM || state == ADDR || state == COUNT || (state == DATA && !last_q);
    tx_data = state == CKSUM ? ck_q : state == ADDR ? addr_q : state == COUNT ? fill_q[7:0] : mem[idx];
  end
  // the done cycle already behaves as idle with an empty buffer
  always_comb begin
    fill_eff = done ? 9'd0 : fill_q;
    sum_eff = done ? 8'd0 : sum_q;
    wr_ok = wr && !busy && fill_eff != 9'(MAX_PAYLOAD);
    fill_n = fill_eff + {8'd0, wr_ok};
    sum_n = sum_eff + (wr_ok ? wr_data : 8'd0);
    start = commit && !busy && fill_n != 9'd0;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      fill_q <= '0;
      sum_q <= '0;
      idx <= '0;
      last_q <= 1'b0;
    end else begin
      fill_q <= fill_n;
      sum_q <= sum_n;
      if (start) begin
        addr_q <= commit_addr;
        ck_q <= cksum(commit_addr, fill_n[7:0], sum_n);
        idx <= '0;
        last_q <= 1'b0;
      end else if (state == DATA && ready && !last_q) begin
        idx <= idx + 1'b1;
        last_q <= {1'b0, idx} == fill_q - 9'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[fill_eff[7:0]] <= wr_data;
  end
  assign fill = fill_eff;
`ifdef UART_MUX_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (RESET) ovf_q <= 1'b0;
    else if (wr && !wr_ok) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .RESET(RESET),
    .valid(valid),
    .data(tx_data),
    .ready(ready),
    .tx(UART_TX)
  );
endmodule

// File: tb/tb_uart_mux.sv
// tb_uart_mux: table vectors, hand sequences and random packets checked against a packet-level model.
module tb_uart_mux;
  localparam int CPB = 4;
  localparam int S = 10 * CPB + 1;
`ifdef UART_MUX_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  typedef logic [7:0] bq_t [$];
  typedef struct {
    bit wr; logic [7:0] d; bit cm; logic [7:0] a;
    logic [8:0] fill; bit busy; bit tx; bit ovf;
  } vec_t;
  logic clk = 1'b0, RESET, wr, commit, UART_TX, busy, done, overflow;
  logic [7:0] wr_data, commit_addr;
  logic [8:0] fill;
  int cyc = 0, done_cnt = 0, stop_bad = 0, n_chk = 0, n_fail = 0;
  int tc, mb;
  logic [7:0] ta;
  logic [7:0] rx_q [$];
  int rx_t [$];
  bq_t mq;
  vec_t tv [8];

  uart_mux #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .RESET(RESET), .wr(wr), .wr_data(wr_data), .commit(commit),
    .commit_addr(commit_addr), .UART_TX(UART_TX), .busy(busy), .fill(fill),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // line receiver: samples mid-bit, records each byte with the cycle its start bit appeared
  initial forever begin
    @(negedge clk);
    if (UART_TX === 1'b0) begin
      int t0;
      logic [7:0] b;
      t0 = cyc;
      b = 8'h00;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = UART_TX;
      end
      repeat (CPB) @(negedge clk);
      if (UART_TX !== 1'b1) stop_bad++;
      rx_q.push_back(b);
      rx_t.push_back(t0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void build(input logic [7:0] a, input bq_t d, output bq_t p);
    int s;
    s = a + d.size();
    foreach (d[i]) s += d[i];
    p = {};
    p.push_back(8'((256 - s % 256) % 256));
    p.push_back(a);
    p.push_back(8'(d.size() % 256));
    foreach (d[i]) p.push_back(d[i]);
  endfunction

  task automatic wr_byte(input logic [7:0] b);
    wr = 1'b1;
    wr_data = b;
    if (mq.size() < 256) mq.push_back(b);
    @(negedge clk);
    wr = 1'b0;
  endtask

  // caller has just driven the accepted commit at cycle tc; follow the packet to done and check it
  task automatic send_check(input logic [7:0] a, input bit drops, input bit wr_done, input logic [7:0] wd);
    bq_t exp;
    int at, bb, fb, nd, sp, n, dc0, sb0;
    build(a, mq, exp);
    n = mq.size();
    dc0 = done_cnt;
    sb0 = stop_bad;
    rx_q.delete();
    rx_t.delete();
    at = -1; bb = 0; fb = 0; nd = 0;
    for (int k = 0; k < (n + 4) * S + 50; k++) begin
      @(negedge clk);
      wr = 1'b0;
      commit = 1'b0;
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
      if (busy !== 1'b1) bb++;
      if (fill !== 9'(n)) fb++;
      if (drops && $urandom_range(0, 3) == 0) begin
        wr = 1'b1;
        wr_data = 8'($urandom);
        nd++;
      end
    end
    chk("done_seen", at >= 0, 1);
    chk("busy_hold", bb, 0);
    chk("fill_hold", fb, 0);
    if (at >= 0) begin
      chk("busy_at_done", busy, 0);
      chk("fill_at_done", fill, 0);
      if (wr_done) begin
        wr = 1'b1;
        wr_data = wd;
      end
      @(negedge clk);
      wr = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("fill_after_done", fill, wr_done ? 1 : 0);
      chk("done_pulses", done_cnt - dc0, 1);
      if (rx_t.size() > 0) chk("done_time", at, rx_t[0] + (n + 3) * S - 1);
    end
    if (nd > 0) chk("overflow_drop", overflow, OVF);
    chk("rx_count", rx_q.size(), exp.size());
    if (rx_q.size() == exp.size()) begin
      foreach (exp[i]) chk($sformatf("byte%0d", i), rx_q[i], exp[i]);
      sp = 0;
      for (int i = 1; i < rx_t.size(); i++) if (rx_t[i] - rx_t[i-1] != S) sp++;
      chk("byte_spacing", sp, 0);
    end
    if (rx_t.size() > 0) chk("first_start", rx_t[0], tc + 2);
    chk("stop_bits", stop_bad - sb0, 0);
    mq.delete();
    if (wr_done) mq.push_back(wd);
  endtask

  initial begin
    tv[0] = '{1'b0, 8'h00, 1'b1, 8'h55, 9'd0, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 9'd0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 8'h11, 1'b0, 8'h00, 9'd1, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 8'h22, 1'b0, 8'h00, 9'd2, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 8'h33, 1'b1, 8'h12, 9'd3, 1'b1, 1'b1, 1'b0};
    tv[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 9'd3, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1'b1, 8'h44, 1'b0, 8'h00, 9'd3, 1'b1, 1'b0, OVF};
    tv[7] = '{1'b0, 8'h00, 1'b1, 8'h77, 9'd3, 1'b1, 1'b0, OVF};
    RESET = 1'b1; wr = 1'b0; wr_data = 8'h00; commit = 1'b0; commit_addr = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", UART_TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fill", fill, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    RESET = 1'b0;

    // idle-phase vectors, ending with a commit, a write while busy and a commit while busy
    mb = 0;
    for (int i = 0; i < 8; i++) begin
      wr = tv[i].wr; wr_data = tv[i].d; commit = tv[i].cm; commit_addr = tv[i].a;
      if (tv[i].wr && mb == 0 && mq.size() < 256) mq.push_back(tv[i].d);
      if (tv[i].cm && mb == 0 && mq.size() > 0) begin
        mb = 1;
        tc = cyc;
        ta = tv[i].a;
      end
      @(negedge clk);
      chk($sformatf("vec%0d_fill", i), fill, tv[i].fill);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("vec%0d_tx", i), UART_TX, tv[i].tx);
      chk($sformatf("vec%0d_ovf", i), overflow, tv[i].ovf);
    end
    wr = 1'b0; commit = 1'b0;
    send_check(ta, 1'b0, 1'b1, 8'h5A);
    commit = 1'b1; commit_addr = 8'h99; tc = cyc;
    send_check(8'h99, 1'b1, 1'b0, 8'h00);

    // commit with an empty buffer does nothing
    rx_q.delete();
    mb = done_cnt;
    commit = 1'b1; commit_addr = 8'h42;
    @(negedge clk);
    commit = 1'b0;
    chk("empty_busy", busy, 0);
    repeat (3 * CPB) @(negedge clk);
    chk("empty_tx", UART_TX, 1);
    chk("empty_rx", rx_q.size(), 0);
    chk("empty_done", done_cnt - mb, 0);

    // single byte 0x34 to address 0x12
    wr_byte(8'h34);
    commit = 1'b1; commit_addr = 8'h12; tc = cyc;
    send_check(8'h12, 1'b0, 1'b0, 8'h00);
    if (rx_q.size() == 4) begin
      chk("spec1_cksum", rx_q[0], 8'hB9);
      chk("spec1_addr", rx_q[1], 8'h12);
      chk("spec1_count", rx_q[2], 8'h01);
      chk("spec1_data", rx_q[3], 8'h34);
    end

    // full 256-byte buffer plus one dropped write
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    mq.delete();
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < 256; i++) wr_byte(8'(i));
    chk("fill_full", fill, 256);
    chk("ovf_before_drop", overflow, 0);
    wr_byte(8'hEE);
    chk("fill_stays_full", fill, 256);
    chk("ovf_full_drop", overflow, OVF);
    commit = 1'b1; commit_addr = 8'h00; tc = cyc;
    send_check(8'h00, 1'b0, 1'b0, 8'h00);
    if (rx_q.size() == 259) begin
      chk("full_cksum", rx_q[0], 8'h80);
      chk("full_count", rx_q[2], 8'h00);
      chk("full_last", rx_q[258], 8'hFF);
    end

    // reset while the ADDR byte is on the line, then a fresh packet
    wr_byte(8'h77);
    commit = 1'b1; commit_addr = 8'h21; tc = cyc;
    @(negedge clk);
    commit = 1'b0;
    repeat (S + 8) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    mq.delete();
    chk("midrst_tx", UART_TX, 1);
    chk("midrst_fill", fill, 0);
    chk("midrst_busy", busy, 0);
    repeat (12 * CPB + 4) @(negedge clk);
    chk("midrst_idle_tx", UART_TX, 1);
    chk("midrst_idle_busy", busy, 0);
    wr_byte(8'h77);
    commit = 1'b1; commit_addr = 8'h21; tc = cyc;
    send_check(8'h21, 1'b0, 1'b0, 8'h00);

    // random packets, sometimes committing with the last write, with drops while busy
    for (int p = 0; p < 6; p++) begin
      int n;
      logic [7:0] a;
      bit same;
      n = $urandom_range(1, 12);
      a = 8'($urandom);
      same = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        wr = 1'b1;
        wr_data = 8'($urandom);
        mq.push_back(wr_data);
      end
      if (!same) begin
        @(negedge clk);
        wr = 1'b0;
      end
      commit = 1'b1; commit_addr = a; tc = cyc;
      send_check(a, 1'b1, 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
